// File: rtl/aes_key_sched_iter.sv
// rtl/aes_key_sched_iter.sv - word-serial AES-128/192/256 key expansion with a shared registered S-box word
module aes_key_sched_iter #(
   parameter int NK = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [255:0] key,
   output logic         busy,
   output logic [31:0]  out_word,
   output logic [5:0]   out_idx,
   output logic         out_valid,
   input  logic         out_ready,
   output logic         done
);
   localparam int NR = NK + 6;
   localparam int NW = 4 * (NR + 1);
   localparam int IW = $clog2(NK);

   if (NK != 4 && NK != 6 && NK != 8) begin : g_bad_nk
      $error("aes_key_sched_iter: NK must be 4, 6 or 8");
   end

   localparam logic [2047:0] SBOX = {
      128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
   };

   function automatic logic [7:0] sbox(input logic [7:0] x);
      return SBOX[2047 - 8*int'(x) -: 8];
   endfunction

   typedef enum logic [2:0] {IDLE, KEYOUT, SUBW, CALC, FIN} state_t;

   state_t      state_q, state_d;
   logic [31:0] sr [NK];      // sr[0] = w[i-NK], sr[NK-1] = w[i-1]
   logic [5:0]  i_q;
   logic [2:0]  phase_q;      // i mod NK, tracked alongside i
   logic [7:0]  rcon_q;
   logic [31:0] sbox_q;
   logic [31:0] prev, s4_in, temp, w_new;
   logic        unused_key;

   assign unused_key = ^key;

   always_comb begin
      prev  = sr[NK-1];
      s4_in = (phase_q == 3'd0) ? {prev[23:0], prev[31:24]} : prev;
      if (phase_q == 3'd0)
         temp = sbox_q ^ {rcon_q, 24'h0};
      else if (NK == 8 && phase_q == 3'd4)
         temp = sbox_q;
      else
         temp = prev;
      w_new = sr[0] ^ temp;
   end

   always_comb begin
      state_d   = state_q;
      busy      = 1'b0;
      out_valid = 1'b0;
      out_word  = 32'h0;
      out_idx   = 6'h0;
      done      = 1'b0;
      unique case (state_q)
         IDLE: if (start) state_d = KEYOUT;
         KEYOUT: begin
            busy      = 1'b1;
            out_valid = 1'b1;
            out_word  = sr[i_q[IW-1:0]];
            out_idx   = i_q;
            if (out_ready && i_q == 6'(NK-1)) state_d = SUBW;
         end
         SUBW: begin
            busy    = 1'b1;
            state_d = CALC;
         end
         CALC: begin
            busy      = 1'b1;
            out_valid = 1'b1;
            out_word  = w_new;
            out_idx   = i_q;
            if (out_ready) state_d = (i_q == 6'(NW-1)) ? FIN : SUBW;
         end
         FIN: begin
            busy    = 1'b1;
            done    = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         i_q     <= 6'h0;
         phase_q <= 3'h0;
         rcon_q  <= 8'h01;
         sbox_q  <= 32'h0;
         for (int j = 0; j < NK; j++) sr[j] <= 32'h0;
      end else begin
         state_q <= state_d;
         // S-box input is a function of held state, so it stays stable through CALC stalls
         sbox_q  <= {sbox(s4_in[31:24]), sbox(s4_in[23:16]), sbox(s4_in[15:8]), sbox(s4_in[7:0])};
         case (state_q)
            IDLE: if (start) begin
               for (int j = 0; j < NK; j++) sr[j] <= key[255-32*j -: 32];
               i_q     <= 6'h0;
               phase_q <= 3'h0;
               rcon_q  <= 8'h01;
            end
            KEYOUT: if (out_ready) begin
               i_q     <= i_q + 6'd1;
               phase_q <= (phase_q == 3'(NK-1)) ? 3'd0 : phase_q + 3'd1;
            end
            CALC: if (out_ready) begin
               for (int j = 0; j < NK-1; j++) sr[j] <= sr[j+1];
               sr[NK-1] <= w_new;
               i_q      <= i_q + 6'd1;
               phase_q  <= (phase_q == 3'(NK-1)) ? 3'd0 : phase_q + 3'd1;
               if (phase_q == 3'd0)
                  rcon_q <= {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1b : 8'h00);
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_aes_key_sched_iter.sv
// tb/tb_aes_key_sched_iter.sv - scoreboard bench for aes_key_sched_iter at NK=4, 6 and 8
module tb_aes_key_sched_iter;
   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic [2:0]   start = 3'b000;
   logic [2:0]   out_ready = 3'b111;
   logic [255:0] key [3];
   logic [2:0]   busy, out_valid, done;
   logic [31:0]  out_word [3];
   logic [5:0]   out_idx [3];

   int checks = 0;
   int errors = 0;
   logic [37:0] sbq [$];
   logic [31:0] cap [64];
   int          cap_n;
   logic [7:0]  sbm [256];

   localparam logic [255:0] KEY128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0123456789abcdeffedcba9876543210};
   localparam logic [255:0] KEY192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'hffffffffffffffff};
   localparam logic [255:0] KEY256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

   always #5 clk = ~clk;

   aes_key_sched_iter #(.NK(4)) u_nk4 (.clk(clk), .rst(rst), .start(start[0]), .key(key[0]), .busy(busy[0]),
      .out_word(out_word[0]), .out_idx(out_idx[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]), .done(done[0]));
   aes_key_sched_iter #(.NK(6)) u_nk6 (.clk(clk), .rst(rst), .start(start[1]), .key(key[1]), .busy(busy[1]),
      .out_word(out_word[1]), .out_idx(out_idx[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]), .done(done[1]));
   aes_key_sched_iter #(.NK(8)) u_nk8 (.clk(clk), .rst(rst), .start(start[2]), .key(key[2]), .busy(busy[2]),
      .out_word(out_word[2]), .out_idx(out_idx[2]), .out_valid(out_valid[2]), .out_ready(out_ready[2]), .done(done[2]));

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p, aa;
      p = 8'h0;
      aa = a;
      for (int j = 0; j < 8; j++) begin
         if (b[j]) p = p ^ aa;
         aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
      end
      return p;
   endfunction

   // S-box derived from the GF(2^8) inverse plus affine map, independent of any table
   task automatic build_sbox();
      logic [7:0] inv, r, s;
      for (int x = 0; x < 256; x++) begin
         inv = 8'h0;
         for (int y = 1; y < 256; y++)
            if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
         r = inv;
         s = inv;
         repeat (4) begin
            r = {r[6:0], r[7]};
            s = s ^ r;
         end
         sbm[x] = s ^ 8'h63;
      end
   endtask

   function automatic logic [31:0] subw(input logic [31:0] t);
      return {sbm[t[31:24]], sbm[t[23:16]], sbm[t[15:8]], sbm[t[7:0]]};
   endfunction

   task automatic model_push(input int nk, input logic [255:0] kv);
      logic [31:0] w [60];
      logic [31:0] t;
      logic [7:0]  rc;
      int          nw;
      nw = 4 * (nk + 7);
      for (int i = 0; i < nw; i++) begin
         if (i < nk) begin
            w[i] = kv[255-32*i -: 32];
         end else begin
            t = w[i-1];
            if (i % nk == 0) begin
               rc = 8'h01;
               for (int j = 1; j < i / nk; j++) rc = gmul(rc, 8'h02);
               t = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
            end else if (nk > 6 && i % nk == 4) begin
               t = subw(t);
            end
            w[i] = w[i-nk] ^ t;
         end
         sbq.push_back({6'(i), w[i]});
      end
   endtask

   task automatic start_key(input int k, input logic [255:0] kv);
      sbq.delete();
      model_push(4 + 2*k, kv);
      key[k] = kv;
      start[k] = 1'b1;
      @(posedge clk); #1;
      start[k] = 1'b0;
      key[k] = ~kv;
   endtask

   // Consumes one stream; returns done cycle (start cycle = 0), -1 on timeout, -2 if reset was applied
   task automatic drain(input int k, input int ready_pct, input int inject_at, input logic [255:0] alt_key,
                        input int reset_at, output int done_cyc);
      int          cyc;
      bit          stall, injected, quiet;
      logic [31:0] lw;
      logic [5:0]  li;
      logic [37:0] exp_e;
      done_cyc = -1;
      cyc = 1;
      stall = 1'b0;
      injected = 1'b0;
      cap_n = 0;
      while (1) begin
         start[k] = 1'b0;
         if (cyc == 1) begin
            checks++;
            if (out_valid[k] !== 1'b1 || out_idx[k] !== 6'd0) begin
               errors++;
               $display("FAIL w0_latency k=%0d: valid=%b idx=%0d, required valid=1 idx=0", k, out_valid[k], out_idx[k]);
            end
         end
         if (stall) begin
            checks++;
            if (out_valid[k] !== 1'b1 || out_word[k] !== lw || out_idx[k] !== li) begin
               errors++;
               $display("FAIL stall_hold k=%0d: valid=%b word=%h idx=%0d, required 1 %h %0d", k, out_valid[k], out_word[k], out_idx[k], lw, li);
            end
         end
         if (done[k]) begin
            done_cyc = cyc;
            checks++;
            if (sbq.size() != 0 || out_valid[k] !== 1'b0) begin
               errors++;
               $display("FAIL done_early k=%0d: %0d words left, valid=%b, required 0 left and valid=0", k, sbq.size(), out_valid[k]);
            end
            break;
         end
         out_ready[k] = ($urandom_range(0, 99) < ready_pct);
         if (out_valid[k] && out_ready[k]) begin
            checks++;
            if (sbq.size() == 0) begin
               errors++;
               $display("FAIL extra_word k=%0d: got idx %0d word %h, required no transfer", k, out_idx[k], out_word[k]);
            end else begin
               exp_e = sbq.pop_front();
               if ({out_idx[k], out_word[k]} !== exp_e) begin
                  errors++;
                  $display("FAIL word k=%0d: got idx %0d %h, required idx %0d %h", k, out_idx[k], out_word[k], exp_e[37:32], exp_e[31:0]);
               end
            end
            cap[out_idx[k]] = out_word[k];
            cap_n++;
         end
         stall = out_valid[k] && !out_ready[k];
         lw = out_word[k];
         li = out_idx[k];
         if (out_valid[k] && int'(out_idx[k]) == inject_at && !injected) begin
            injected = 1'b1;
            start[k] = 1'b1;
            key[k] = alt_key;
         end
         if (out_valid[k] && int'(out_idx[k]) == reset_at) begin
            rst = 1'b1;
            @(posedge clk); #1;
            rst = 1'b0;
            checks++;
            if (out_valid[k] !== 1'b0 || busy[k] !== 1'b0 || done[k] !== 1'b0) begin
               errors++;
               $display("FAIL reset_mid k=%0d: valid=%b busy=%b done=%b, required all 0", k, out_valid[k], busy[k], done[k]);
            end
            quiet = 1'b1;
            repeat (3) begin
               @(posedge clk); #1;
               if (done[k] !== 1'b0 || busy[k] !== 1'b0) quiet = 1'b0;
            end
            checks++;
            if (!quiet) begin
               errors++;
               $display("FAIL reset_quiet k=%0d: done or busy seen after reset, required none", k);
            end
            sbq.delete();
            done_cyc = -2;
            out_ready[k] = 1'b1;
            return;
         end
         if (cyc >= 3000) begin
            checks++;
            errors++;
            $display("FAIL timeout k=%0d: no done after %0d cycles, required done", k, cyc);
            break;
         end
         @(posedge clk); #1;
         cyc++;
      end
      out_ready[k] = 1'b1;
      if (done_cyc > 0) begin
         @(posedge clk); #1;
         checks++;
         if (busy[k] !== 1'b0 || done[k] !== 1'b0) begin
            errors++;
            $display("FAIL after_done k=%0d: busy=%b done=%b, required 0 0", k, busy[k], done[k]);
         end
      end
   endtask

   task automatic check_val(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h, required %h", name, got, exp);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      for (int k = 0; k < 3; k++) begin
         checks++;
         if (busy[k] !== 1'b0 || out_valid[k] !== 1'b0 || done[k] !== 1'b0 || out_word[k] !== 32'h0 || out_idx[k] !== 6'h0) begin
            errors++;
            $display("FAIL reset k=%0d: busy=%b valid=%b done=%b word=%h idx=%0d, required all 0",
                     k, busy[k], out_valid[k], done[k], out_word[k], out_idx[k]);
         end
      end
      rst = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_nk4_vector();
      int dc;
      start_key(0, KEY128);
      drain(0, 100, -1, '0, -1, dc);
      check_val("nk4_done_cycle", 32'(dc), 32'd85);
      check_val("nk4_w4", cap[4], 32'ha0fafe17);
      check_val("nk4_w43", cap[43], 32'hb6630ca6);
      check_val("nk4_count", 32'(cap_n), 32'd44);
   endtask

   task automatic test_nk6_vector();
      int dc;
      start_key(1, KEY192);
      drain(1, 100, -1, '0, -1, dc);
      check_val("nk6_done_cycle", 32'(dc), 32'd99);
      check_val("nk6_w6", cap[6], 32'hfe0c91f7);
      check_val("nk6_w51", cap[51], 32'h01002202);
      check_val("nk6_count", 32'(cap_n), 32'd52);
   endtask

   task automatic test_nk8_vector();
      int dc;
      start_key(2, KEY256);
      drain(2, 100, -1, '0, -1, dc);
      check_val("nk8_done_cycle", 32'(dc), 32'd113);
      check_val("nk8_w8", cap[8], 32'h9ba35411);
      check_val("nk8_w12", cap[12], 32'ha8b09c1a);
      check_val("nk8_w59", cap[59], 32'h706c631e);
      check_val("nk8_count", 32'(cap_n), 32'd60);
   endtask

   task automatic test_backpressure();
      int dc;
      start_key(0, KEY128);
      drain(0, 50, -1, '0, -1, dc);
      check_val("bp_count", 32'(cap_n), 32'd44);
      check_val("bp_w43", cap[43], 32'hb6630ca6);
   endtask

   task automatic test_start_ignored();
      int dc;
      start_key(0, KEY128);
      drain(0, 100, 10, KEY256, -1, dc);
      check_val("restart_done_cycle", 32'(dc), 32'd85);
      check_val("restart_w43", cap[43], 32'hb6630ca6);
   endtask

   task automatic test_reset_mid();
      int dc;
      start_key(0, KEY128);
      drain(0, 100, -1, '0, 20, dc);
      start_key(0, KEY256);
      drain(0, 100, -1, '0, -1, dc);
      check_val("post_reset_w0", cap[0], 32'h603deb10);
      check_val("post_reset_count", 32'(cap_n), 32'd44);
   endtask

   task automatic test_random_keys();
      int dc;
      logic [255:0] kv;
      for (int k = 0; k < 3; k++) begin
         for (int n = 0; n < 34; n++) begin
            for (int b = 0; b < 8; b++) kv[32*b +: 32] = $urandom();
            start_key(k, kv);
            drain(k, 75, -1, '0, -1, dc);
            checks++;
            if (cap_n != 4 * (4 + 2*k + 7)) begin
               errors++;
               $display("FAIL random_count k=%0d: got %0d words, required %0d", k, cap_n, 4 * (4 + 2*k + 7));
            end
         end
      end
   endtask

   initial begin
      for (int k = 0; k < 3; k++) key[k] = '0;
      build_sbox();
      @(posedge clk); #1;
      test_reset();
      test_nk4_vector();
      test_nk6_vector();
      test_nk8_vector();
      test_backpressure();
      test_start_ignored();
      test_reset_mid();
      test_random_keys();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
